dmem_responder: RTL and testbench

Data-memory responder for the pipelined RV32 core: the target side of the MEM-stage load/store interface. Accepts one request at a time over a valid/ready handshake, waits a parameterised access latency, commits stores with RV32 byte/halfword/word lane masking, and returns sign/zero-extended load data with an error flag. It replaces the zero-latency data array, so stall-aware MEM stages can be built against a realistic memory.

---
 rtl/dmem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 MEM stage. It takes one request at a
// time, waits LATENCY cycles, then commits a lane-masked store or returns
// sign/zero-extended load data. The response is held until it is consumed.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. req_ready comes from a register and rsp_valid is a state decode,
// so neither ready depends on the other side's valid. rsp_rdata and rsp_error
// stay stable while rsp_valid is high.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [1:0]  dbgState
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;
    logic        readyQ;

    logic        wrQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [2:0]  funct3Q;
    logic [31:0] rdataQ;
    logic        errorQ;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             doAccess;
    logic             accWrite;
    logic [31:0]      accAddr;
    logic [31:0]      accWdata;
    logic [2:0]       accFunct3;
    logic             badFunct;
    logic             misalign;
    logic             outRange;
    logic             accErr;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      curWord;
    logic [31:0]      shifted;
    logic [31:0]      loadData;
    logic [3:0]       byteEn;
    logic [31:0]      laneData;

    assign accept    = req_valid && readyQ;
    assign req_ready = readyQ;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdataQ;
    assign rsp_error = errorQ;
    assign dbgState  = state;

    // The access fires on the edge entering RESP; with LATENCY=1 that is the
    // accept edge itself, so the live request inputs are used instead of the
    // latched copy.
    assign doAccess = ((state == IDLE) && accept && (LATENCY == 1)) ||
                      ((state == WAIT) && (cnt <= 4'd1));

    // Choose the request being serviced and decode its errors and lanes.
    always_comb begin
        accWrite  = wrQ;
        accAddr   = addrQ;
        accWdata  = wdataQ;
        accFunct3 = funct3Q;
        if (state == IDLE) begin
            accWrite  = req_write;
            accAddr   = req_addr;
            accWdata  = req_wdata;
            accFunct3 = req_funct3;
        end

        if (accWrite) begin
            badFunct = (accFunct3 > 3'd2);
        end else begin
            badFunct = (accFunct3[1:0] == 2'b11) || (accFunct3 == 3'd6);
        end
        misalign = ((accFunct3[1:0] == 2'd1) && accAddr[0]) ||
                   ((accFunct3[1:0] == 2'd2) && (accAddr[1:0] != 2'b00));
        outRange = (accAddr[31:IDX_W+2] != '0);
        accErr   = badFunct || misalign || outRange;

        wordIdx = accAddr[IDX_W+1:2];
        curWord = mem[wordIdx];
        shifted = curWord >> {accAddr[1:0], 3'b000};

        loadData = 32'h0;
        case (accFunct3)
            3'd0:    loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    loadData = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    loadData = curWord;
            3'd4:    loadData = {24'h0, shifted[7:0]};
            3'd5:    loadData = {16'h0, shifted[15:0]};
            default: loadData = 32'h0;
        endcase

        byteEn   = 4'b1111;
        laneData = accWdata;
        case (accFunct3[1:0])
            2'd0: begin
                byteEn   = 4'b0001 << accAddr[1:0];
                laneData = {4{accWdata[7:0]}};
            end
            2'd1: begin
                byteEn   = accAddr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{accWdata[15:0]}};
            end
            default: begin
                byteEn   = 4'b1111;
                laneData = accWdata;
            end
        endcase
    end

    // Next-state logic and latency counter update.
    always_comb begin
        nextState = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cntNext   = 4'(LATENCY - 1);
                    nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    cntNext   = 4'd0;
                    nextState = RESP;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            readyQ  <= 1'b0;
            cnt     <= 4'd0;
            wrQ     <= 1'b0;
            addrQ   <= 32'h0;
            wdataQ  <= 32'h0;
            funct3Q <= 3'd0;
            rdataQ  <= 32'h0;
            errorQ  <= 1'b0;
        end else begin
            state  <= nextState;
            readyQ <= (nextState == IDLE);
            cnt    <= cntNext;
            if (accept) begin
                wrQ     <= req_write;
                addrQ   <= req_addr;
                wdataQ  <= req_wdata;
                funct3Q <= req_funct3;
            end
            if (doAccess) begin
                rdataQ <= (accErr || accWrite) ? 32'h0 : loadData;
                errorQ <= accErr;
            end
        end
    end

    // Byte-lane store commit; reset blocks a commit on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && doAccess && accWrite && !accErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 4 and 1) driven by
// directed sequences and random traffic, checked against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst       [3];
    logic        reqValid  [3];
    logic        reqReady  [3];
    logic        reqWrite  [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic [2:0]  reqFunct3 [3];
    logic        rspValid  [3];
    logic        rspReady  [3];
    logic [31:0] rspRdata  [3];
    logic        rspError  [3];
    logic [1:0]  dbgState  [3];

    bit [31:0]   mdl [3][DEPTH];
    logic [31:0] expQ[$];
    int          nCompared;
    int          nMismatched;
    int          cyc;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_write(reqWrite[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
        .req_funct3(reqFunct3[0]), .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
        .rsp_rdata(rspRdata[0]), .rsp_error(rspError[0]), .dbgState(dbgState[0]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_write(reqWrite[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
        .req_funct3(reqFunct3[1]), .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
        .rsp_rdata(rspRdata[1]), .rsp_error(rspError[1]), .dbgState(dbgState[1]));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut2 (
        .clk(clk), .reset(rst[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
        .req_write(reqWrite[2]), .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
        .req_funct3(reqFunct3[2]), .rsp_valid(rspValid[2]), .rsp_ready(rspReady[2]),
        .rsp_rdata(rspRdata[2]), .rsp_error(rspError[2]), .dbgState(dbgState[2]));

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic int latOf(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: applies the access rules to a plain word array.
    task automatic refAccess(input int d, input bit wr, input bit [31:0] a, input bit [31:0] wd,
                             input bit [2:0] f3, output bit err, output bit [31:0] rd);
        int        nBytes;
        int        sh;
        bit [31:0] w;
        bit [31:0] mask;
        bit [31:0] v;
        err = 1'b0;
        rd  = 32'h0;
        if (wr) err = (f3 > 3'd2);
        else    err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        nBytes = 1 << (f3 % 4);
        if (!err && (a % nBytes) != 0) err = 1'b1;
        if (!err && (a / 4) >= DEPTH) err = 1'b1;
        if (err) return;
        w  = mdl[d][a / 4];
        sh = 8 * int'(a % 4);
        if (wr) begin
            if (nBytes == 4) mask = 32'hFFFF_FFFF;
            else             mask = ((32'h1 << (8 * nBytes)) - 32'h1) << sh;
            mdl[d][a / 4] = (w & ~mask) | ((wd << sh) & mask);
        end else begin
            v = w >> sh;
            if (nBytes == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (nBytes == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            rd = v;
        end
    endtask

    // Driver: one full request/response transaction with optional back-pressure.
    task automatic doReq(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input int hold, output int accCyc,
                         output logic [31:0] gotRd, output logic gotErr);
        bit          expErr;
        bit [31:0]   expRd;
        logic [31:0] expPop;
        int          n;
        n = 0;
        while (!reqReady[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady[d]) checkVal("req_ready_wait", 32'(reqReady[d]), 32'd1);
        reqValid[d]  = 1'b1;
        reqWrite[d]  = wr;
        reqAddr[d]   = a;
        reqWdata[d]  = wd;
        reqFunct3[d] = f3;
        rspReady[d]  = (d == 2) || (hold == 0);
        @(posedge clk);
        #1;
        accCyc = cyc;
        refAccess(d, wr, a, wd, f3, expErr, expRd);
        expQ.push_back(expRd);
        // Garbage with valid held high: must be ignored outside IDLE.
        reqWrite[d]  = 1'($urandom);
        reqAddr[d]   = $urandom;
        reqWdata[d]  = $urandom;
        reqFunct3[d] = 3'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rspValid[d] && n < 40);
        checkVal("latency", 32'(n), 32'(latOf(d)));
        expPop = expQ.pop_front();
        gotRd  = rspRdata[d];
        gotErr = rspError[d];
        checkVal("rsp_rdata", rspRdata[d], expPop);
        checkVal("rsp_error", 32'(rspError[d]), 32'(expErr));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkVal("bp_valid", 32'(rspValid[d]), 32'd1);
            checkVal("bp_rdata", rspRdata[d], expPop);
            checkVal("bp_error", 32'(rspError[d]), 32'(expErr));
            checkVal("bp_req_ready", 32'(reqReady[d]), 32'd0);
        end
        reqValid[d] = 1'b0;
        rspReady[d] = 1'b1;
        @(posedge clk);
        #1;
        rspReady[d] = (d == 2);
        @(negedge clk);
        checkVal("ready_after_rsp", 32'(reqReady[d]), 32'd1);
        checkVal("valid_after_rsp", 32'(rspValid[d]), 32'd0);
    endtask

    // Accept a store, then reset after waitCyc cycles (WAIT or RESP).
    task automatic storeThenReset(input int d, input logic [31:0] a, input logic [31:0] wd,
                                  input int waitCyc, input bit commit);
        bit        e;
        bit [31:0] r;
        reqValid[d]  = 1'b1;
        reqWrite[d]  = 1'b1;
        reqAddr[d]   = a;
        reqWdata[d]  = wd;
        reqFunct3[d] = 3'd2;
        rspReady[d]  = 1'b0;
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
        for (int i = 0; i < waitCyc; i++) @(negedge clk);
        checkVal("pre_reset_valid", 32'(rspValid[d]), 32'(commit));
        if (commit) refAccess(d, 1'b1, a, wd, 3'd2, e, r);
        rst[d] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkVal("midrst_req_ready", 32'(reqReady[d]), 32'd0);
            checkVal("midrst_rsp_valid", 32'(rspValid[d]), 32'd0);
        end
        rst[d] = 1'b0;
        rspReady[d] = (d == 2);
        @(negedge clk);
        checkVal("post_rst_ready", 32'(reqReady[d]), 32'd1);
    endtask

    initial begin
        int          acc;
        int          prevAcc;
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        nCompared   = 0;
        nMismatched = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b1;
            reqValid[d]  = 1'b0;
            reqWrite[d]  = 1'b0;
            reqAddr[d]   = 32'h0;
            reqWdata[d]  = 32'h0;
            reqFunct3[d] = 3'd0;
            rspReady[d]  = (d == 2);
        end

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkVal("rst_req_ready", 32'(reqReady[d]), 32'd0);
            checkVal("rst_rsp_valid", 32'(rspValid[d]), 32'd0);
            checkVal("rst_rsp_rdata", rspRdata[d], 32'h0);
            checkVal("rst_rsp_error", 32'(rspError[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) checkVal("rst_release_ready", 32'(reqReady[d]), 32'd1);

        // Fill instance 0 so every word has a known value.
        for (int w = 0; w < DEPTH; w++) doReq(0, 1'b1, 32'(w * 4), $urandom, 3'd2, 0, acc, rd, er);

        // Word store/load.
        doReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, acc, rd, er);
        checkVal("tp_sw_rdata", rd, 32'h0);
        doReq(0, 1'b0, 32'h10, 32'h0, 3'd2, 0, acc, rd, er);
        checkVal("tp_lw_10", rd, 32'hDEADBEEF);

        // Byte store and sub-word loads.
        doReq(0, 1'b1, 32'h20, 32'hDEADBEEF, 3'd2, 0, acc, rd, er);
        doReq(0, 1'b1, 32'h21, 32'h000000A5, 3'd0, 0, acc, rd, er);
        doReq(0, 1'b0, 32'h20, 32'h0, 3'd2, 0, acc, rd, er);
        checkVal("tp_sb_word", rd, 32'hDEADA5EF);
        doReq(0, 1'b0, 32'h21, 32'h0, 3'd0, 0, acc, rd, er);
        checkVal("tp_lb", rd, 32'hFFFFFFA5);
        doReq(0, 1'b0, 32'h21, 32'h0, 3'd4, 0, acc, rd, er);
        checkVal("tp_lbu", rd, 32'h000000A5);
        doReq(0, 1'b0, 32'h22, 32'h0, 3'd1, 0, acc, rd, er);
        checkVal("tp_lh", rd, 32'hFFFFDEAD);
        doReq(0, 1'b0, 32'h22, 32'h0, 3'd5, 0, acc, rd, er);
        checkVal("tp_lhu", rd, 32'h0000DEAD);

        // Error cases, then confirm the targeted words are untouched.
        doReq(0, 1'b0, 32'h13, 32'h0, 3'd2, 0, acc, rd, er);
        checkVal("err_lw13", 32'(er), 32'd1);
        doReq(0, 1'b1, 32'h41, 32'hFFFF1234, 3'd1, 0, acc, rd, er);
        checkVal("err_sh41", 32'(er), 32'd1);
        doReq(0, 1'b0, 32'(DEPTH * 4), 32'h0, 3'd2, 0, acc, rd, er);
        checkVal("err_range", 32'(er), 32'd1);
        checkVal("err_range_rdata", rd, 32'h0);
        doReq(0, 1'b1, 32'h10, 32'h55555555, 3'd3, 0, acc, rd, er);
        checkVal("err_st_f3", 32'(er), 32'd1);
        doReq(0, 1'b0, 32'h10, 32'h0, 3'd2, 0, acc, rd, er);
        checkVal("err_word10_kept", rd, 32'hDEADBEEF);
        doReq(0, 1'b0, 32'h40, 32'h0, 3'd2, 0, acc, rd, er);

        // Back-pressure for 5 cycles.
        doReq(0, 1'b0, 32'h10, 32'h0, 3'd2, 5, acc, rd, er);

        // Random traffic.
        for (int k = 0; k < 150; k++) begin
            a = 32'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            doReq(0, 1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), acc, rd, er);
        end

        // Latency 4: reset during WAIT drops the store; reset in RESP keeps it.
        doReq(1, 1'b1, 32'h30, 32'h11111111, 3'd2, 0, acc, rd, er);
        doReq(1, 1'b1, 32'h34, 32'h22222222, 3'd2, 0, acc, rd, er);
        storeThenReset(1, 32'h30, 32'h12345678, 1, 1'b0);
        doReq(1, 1'b0, 32'h30, 32'h0, 3'd2, 0, acc, rd, er);
        checkVal("midrst_dropped", rd, 32'h11111111);
        storeThenReset(1, 32'h34, 32'hCAFEF00D, 4, 1'b1);
        doReq(1, 1'b0, 32'h34, 32'h0, 3'd2, 2, acc, rd, er);
        checkVal("midrst_committed", rd, 32'hCAFEF00D);

        // Latency 1 with rsp_ready tied high: back-to-back every 2 cycles.
        doReq(2, 1'b1, 32'h0, 32'h01020304, 3'd2, 0, prevAcc, rd, er);
        doReq(2, 1'b1, 32'h4, 32'hA0B0C0D0, 3'd2, 0, acc, rd, er);
        checkVal("b2b_spacing", 32'(acc - prevAcc), 32'd2);
        for (int k = 0; k < 8; k++) begin
            prevAcc = acc;
            case (k % 4)
                0: doReq(2, 1'b0, 32'h0, 32'h0, 3'd2, 0, acc, rd, er);
                1: doReq(2, 1'b0, 32'h7, 32'h0, 3'd0, 0, acc, rd, er);
                2: doReq(2, 1'b0, 32'h4, 32'h0, 3'd3, 0, acc, rd, er);
                default: doReq(2, 1'b0, 32'h6, 32'h0, 3'd1, 0, acc, rd, er);
            endcase
            checkVal("b2b_spacing", 32'(acc - prevAcc), 32'd2);
            if (k % 4 == 2) checkVal("lat1_f3_err", 32'(er), 32'd1);
            if (k % 4 == 1) checkVal("lat1_lb", rd, 32'hFFFFFFA0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
